// File: rtl/uart_f2m_pkg.sv
// Shared types and constants for the fabric-to-MSS UART transmitter.
package uart_f2m_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_f2m_fifo.sv
// Synchronous first-word fall-through byte FIFO; head data is valid whenever non-empty.
module uart_f2m_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  // Pointers wrap naturally; occupancy is tracked separately so full/empty are unambiguous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop) begin
        level <= level + 1'b1;
      end else if (do_pop && !do_push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_f2m_tx.sv
// Fabric-side UART transmitter feeding MMUART_0_RXD_F2M; 8N1, or 8E1 when
// UART_F2M_TX_PARITY_EN is defined.
module uart_f2m_tx
  import uart_f2m_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          FAB_CCC_GL0,
  input  logic                          FAB_RESET_N,
  input  logic [7:0]                    TX_DATA,
  input  logic                          TX_VALID,
  output logic                          TX_READY,
  output logic                          TXD_F2M,
  output logic                          TX_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  LAST_IDX    = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t state_q, state_d;
  logic [15:0]    baud_q, baud_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     idx_q, idx_d;
  logic           txd_q, txd_d;
`ifdef UART_F2M_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       tc;

  assign TX_READY = FAB_RESET_N && !fifo_full;
  assign push     = TX_VALID && TX_READY;
  assign TXD_F2M  = txd_q;
  assign TX_BUSY  = (state_q != IDLE) || !fifo_empty;
  assign tc       = (baud_q == '0);

  uart_f2m_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (FAB_CCC_GL0),
    .rst_n (FAB_RESET_N),
    .push  (push),
    .din   (TX_DATA),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (FIFO_LEVEL)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q - 16'd1;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
`ifdef UART_F2M_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        baud_d = BAUD_RELOAD;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          idx_d   = '0;
          state_d = START;
`ifdef UART_F2M_TX_PARITY_EN
          par_d   = ^fifo_dout;
`endif
        end
      end
      START: begin
        if (tc) begin
          baud_d  = BAUD_RELOAD;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tc) begin
          baud_d  = BAUD_RELOAD;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == LAST_IDX) begin
`ifdef UART_F2M_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_F2M_TX_PARITY_EN
      PARITY: begin
        if (tc) begin
          baud_d  = BAUD_RELOAD;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tc) begin
          baud_d = BAUD_RELOAD;
          // A queued byte starts its frame straight out of STOP, with no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            idx_d   = '0;
            state_d = START;
`ifdef UART_F2M_TX_PARITY_EN
            par_d   = ^fifo_dout;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_d  = BAUD_RELOAD;
        state_d = IDLE;
      end
    endcase
  end

  // The line level is computed from the next state so TXD_F2M comes straight from a flop.
  always_comb begin
    txd_d = UART_IDLE_LEVEL;
    case (state_d)
      START:  txd_d = 1'b0;
      DATA:   txd_d = shift_d[0];
`ifdef UART_F2M_TX_PARITY_EN
      PARITY: txd_d = par_d;
`endif
      default: txd_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge FAB_CCC_GL0) begin
    if (!FAB_RESET_N) begin
      state_q <= IDLE;
      baud_q  <= BAUD_RELOAD;
      shift_q <= '0;
      idx_q   <= '0;
      txd_q   <= UART_IDLE_LEVEL;
`ifdef UART_F2M_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
`ifdef UART_F2M_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
